// File: rtl/button_conditioner.sv
// Push-button front end: per channel a two-flop synchroniser, a debouncer and
// registered press/release pulses, plus optional auto-repeat paced by an external tick.
module button_conditioner #(
  parameter int                 NUM_BTN         = 3,
  parameter bit                 ACTIVE_LOW      = 1'b0,
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b011,
  parameter int                 REPEAT_DELAY    = 3,
  parameter int                 REPEAT_PERIOD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DLY   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER   = RW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_st_e;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    logic          s1_q, s2_q, n;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          acc_rise, acc_fall, rep_fire;
    rep_st_e       st_q, st_d;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        st_q      <= ST_IDLE;
        rcnt_q    <= '0;
      end else begin
        s1_q      <= btn_raw[g];
        s2_q      <= s1_q;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        st_q      <= st_d;
        rcnt_q    <= rcnt_d;
      end
    end

    // Debounce: the new level must persist DEBOUNCE_CYCLES enabled cycles in a row.
    always_comb begin
      n       = s2_q ^ ACTIVE_LOW;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (en) begin
        if (n == level_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          level_d = n;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign acc_rise = en &  level_d & ~level_q;
    assign acc_fall = en & ~level_d &  level_q;
    assign rcnt_inc = rcnt_q + 1'b1;

    // Repeat FSM next state; an accepted release wins over a coincident tick.
    always_comb begin
      st_d   = st_q;
      rcnt_d = rcnt_q;
      if (!REPEAT_MASK[g]) begin
        st_d   = ST_IDLE;
        rcnt_d = '0;
      end else if (en) begin
        if (!level_d) begin
          st_d   = ST_IDLE;
          rcnt_d = '0;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (acc_rise) begin
                st_d   = ST_DELAY;
                rcnt_d = '0;
              end
            end
            ST_DELAY: begin
              if (tick) begin
                if (rcnt_inc == R_DLY) begin
                  st_d   = ST_REPEAT;
                  rcnt_d = '0;
                end else begin
                  rcnt_d = rcnt_inc;
                end
              end
            end
            ST_REPEAT: begin
              if (tick) rcnt_d = (rcnt_inc == R_PER) ? '0 : rcnt_inc;
            end
            default: begin
              st_d   = ST_IDLE;
              rcnt_d = '0;
            end
          endcase
        end
      end
    end

    always_comb begin
      rep_fire = 1'b0;
      if (REPEAT_MASK[g] && en && tick && level_d) begin
        rep_fire = ((st_q == ST_DELAY)  && (rcnt_inc == R_DLY)) ||
                   ((st_q == ST_REPEAT) && (rcnt_inc == R_PER));
      end
      press_d   = acc_rise | rep_fire;
      release_d = acc_fall;
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a window/tick-count reference model predicts every cycle's outputs
// for an active-high and an active-low instance fed complementary pins.
module tb_button_conditioner;
  localparam int NB = 3;
  localparam int DC = 4;
  localparam int RD = 3;
  localparam int RP = 2;
  localparam logic [NB-1:0] MASK = 3'b011;

  logic          clk = 1'b0;
  logic          rst_n, en, tick;
  logic [NB-1:0] btn_raw, raw_n;
  logic [NB-1:0] lvl0, prs0, rel0, lvl1, prs1, rel1;

  assign raw_n = ~btn_raw;

  button_conditioner #(.NUM_BTN(NB), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DC),
    .REPEAT_MASK(MASK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .btn_raw(btn_raw),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0));

  button_conditioner #(.NUM_BTN(NB), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DC),
    .REPEAT_MASK(MASK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .btn_raw(raw_n),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: level flips once the last DC enabled samples all oppose it;
  // repeats fire when the count of ticks since acceptance hits RD, RD+RP, RD+2RP, ...
  bit            m_s1[2][NB];
  bit            m_s2[2][NB];
  bit            m_lvl[2][NB];
  logic [DC-1:0] m_win[2][NB];
  int            m_nsamp[2][NB];
  int            m_ticks[2][NB];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t e;
      e = '0;
      for (int i = 0; i < NB; i++) begin
        bit pin, n;
        pin = (d == 0) ? btn_raw[i] : raw_n[i];
        if (!rst_n) begin
          m_s1[d][i] = 0; m_s2[d][i] = 0; m_lvl[d][i] = 0;
          m_win[d][i] = '0; m_nsamp[d][i] = 0; m_ticks[d][i] = 0;
        end else begin
          n = m_s2[d][i] ^ (d == 1);
          if (en) begin
            m_win[d][i] = {m_win[d][i][DC-2:0], n};
            if (m_nsamp[d][i] < DC) m_nsamp[d][i]++;
            if (m_nsamp[d][i] == DC && m_win[d][i] == {DC{!m_lvl[d][i]}}) begin
              m_lvl[d][i] = !m_lvl[d][i];
              if (m_lvl[d][i]) begin
                e.prs[i] = 1'b1;
                m_ticks[d][i] = 0;
              end else begin
                e.rel[i] = 1'b1;
              end
            end else if (m_lvl[d][i] && tick) begin
              m_ticks[d][i]++;
              if (MASK[i] && (m_ticks[d][i] == RD ||
                  (m_ticks[d][i] > RD && (m_ticks[d][i] - RD) % RP == 0)))
                e.prs[i] = 1'b1;
            end
          end
          m_s2[d][i] = m_s1[d][i];
          m_s1[d][i] = pin;
        end
        e.lvl[i] = m_lvl[d][i];
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  end

  task automatic check(input int d, input obs_t want, input obs_t got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL outputs_dut%0d t=%0t got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
               d, $time, got.lvl, got.prs, got.rel, want.lvl, want.prs, want.rel);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a response to pop.
  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front(), {lvl0, prs0, rel0});
    if (q1.size() > 0) check(1, q1.pop_front(), {lvl1, prs1, rel1});
  end

  task automatic cyc_wait(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc_wait(1);
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; tick = 1'b0; btn_raw = '0;
    cyc_wait(2);
    rst_n = 1'b1;
    // clean press on channel 0
    cyc_wait(8);
    btn_raw[0] = 1'b1;
    cyc_wait(10);
    // bounce on channel 1
    btn_raw[1] = 1'b1; cyc_wait(2);
    btn_raw[1] = 1'b0; cyc_wait(2);
    btn_raw[1] = 1'b1; cyc_wait(12);
    // auto-repeat on held channel 0, tick every 10 cycles
    for (int k = 0; k < 9; k++) begin
      pulse_tick();
      cyc_wait(9);
    end
    btn_raw[0] = 1'b0; btn_raw[1] = 1'b0;
    cyc_wait(8);
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      cyc_wait(9);
    end
    // non-repeat channel 2 held over 20 ticks
    btn_raw[2] = 1'b1;
    cyc_wait(8);
    for (int k = 0; k < 20; k++) begin
      pulse_tick();
      cyc_wait(3);
    end
    btn_raw[2] = 1'b0;
    cyc_wait(10);
    // freeze mid-debounce on channel 1
    btn_raw[1] = 1'b1;
    cyc_wait(4);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick = (k % 2 == 0);
      cyc_wait(1);
    end
    tick = 1'b0; en = 1'b1;
    cyc_wait(6);
    btn_raw[1] = 1'b0;
    cyc_wait(8);
    // reset while channel 0 held (dut1 sees it active-low)
    btn_raw[0] = 1'b1;
    cyc_wait(10);
    rst_n = 1'b0;
    cyc_wait(1);
    rst_n = 1'b1;
    cyc_wait(10);
    btn_raw[0] = 1'b0;
    cyc_wait(10);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 19) == 0) btn_raw[i] = ~btn_raw[i];
      tick  = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 15) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc_wait(1);
    end
    btn_raw = '0; en = 1'b1; tick = 1'b0; rst_n = 1'b1;
    cyc_wait(12);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
